// File: rtl/serial_adder_core.sv
// Bit-serial adder: LSB-first operand bit pairs through one full adder with a registered carry,
// result reassembled into a parallel sum. Define SERIAL_ADDER_SUB_EN to add the sub port (A - B).
module serial_adder_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             s_bit,
  output logic             s_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             s_bit_q, s_bit_d;
  logic             s_valid_q, s_valid_d;
  logic             sub_q;
  logic             sub_in;
  logic             b_eff, s_calc, c_calc;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = sub;

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      sub_q <= sub;
    end
  end
`else
  assign sub_in = 1'b0;
  assign sub_q  = 1'b0;
`endif

  // One full adder; inverting B and seeding carry with sub_q gives A + ~B + 1.
  assign b_eff  = b_bit ^ sub_q;
  assign s_calc = a_bit ^ b_eff ^ carry_q;
  assign c_calc = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      sr_q      <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      s_bit_q   <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      sr_q      <= sr_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      s_bit_q   <= s_bit_d;
      s_valid_q <= s_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sr_d      = sr_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    s_bit_d   = s_bit_q;
    s_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          carry_d = sub_in;
        end
      end
      RUN: begin
        if (bit_valid) begin
          carry_d   = c_calc;
          sr_d      = {s_calc, sr_q[WIDTH-1:1]};
          s_bit_d   = s_calc;
          s_valid_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            // Latch the result on the final accept so it is already valid in DONE.
            state_d = DONE;
            sum_d   = {s_calc, sr_q[WIDTH-1:1]};
            cout_d  = c_calc;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign s_bit   = s_bit_q;
  assign s_valid = s_valid_q;
  assign sum     = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_core.sv
// Directed self-checking bench for serial_adder_core (WIDTH=4).
// Subtract cases run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       a_bit = 1'b0;
  logic       b_bit = 1'b0;
  logic       sub = 1'b0;
  logic       busy, s_bit, s_valid, cout, done;
  logic [3:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_core #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bit_valid(bit_valid),
    .a_bit(a_bit),
    .b_bit(b_bit),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy),
    .s_bit(s_bit),
    .s_valid(s_valid),
    .sum(sum),
    .cout(cout),
    .done(done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic sv);
    start = 1'b1;
    sub   = sv;
    cyc();
    start = 1'b0;
    sub   = 1'b0;
  endtask

  task automatic send_pair(input logic a, input logic b);
    bit_valid = 1'b1;
    a_bit = a;
    b_bit = b;
    cyc();
    bit_valid = 1'b0;
    a_bit = 1'b0;
    b_bit = 1'b0;
  endtask

  // Full operation with `gap` idle cycles between pairs; ends in the IDLE cycle after DONE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int gap, input logic sv,
                        output logic [3:0] s_stream, output int n_sv, output int n_done,
                        output int busy_drop);
    int k;
    s_stream = 4'b0; n_sv = 0; n_done = 0; busy_drop = 0; k = 0;
    do_start(sv);
    if (busy !== 1'b1) busy_drop++;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          cyc();
          if (s_valid === 1'b1) n_sv++;
          if (done === 1'b1) n_done++;
          if (busy !== 1'b1) busy_drop++;
        end
      end
      send_pair(a[i], b[i]);
      if (s_valid === 1'b1) begin
        n_sv++;
        if (k < 4) s_stream[k] = s_bit;
        k++;
      end
      if (done === 1'b1) n_done++;
      if (i < 3 && busy !== 1'b1) busy_drop++;
    end
    cyc();
    if (done === 1'b1) n_done++;
    if (s_valid === 1'b1) n_sv++;
    $display("op a=%0d b=%0d sub=%0b gap=%0d -> sum=%b cout=%b dones=%0d svalids=%0d",
             a, b, sv, gap, sum, cout, n_done, n_sv);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (s_bit !== 1'b0) begin errors++; $display("FAIL reset_s_bit got %b exp 0", s_bit); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %b exp 0", s_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (sum !== 4'b0000) begin errors++; $display("FAIL reset_sum got %b exp 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    $display("reset applied");
  endtask

  task automatic test_add();
    logic [3:0] a_v, b_v, exp_s;
    a_v = 4'd5; b_v = 4'd3; exp_s = 4'b1000;
    do_start(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_rise got %b exp 1", busy); end
    for (int i = 0; i < 4; i++) begin
      send_pair(a_v[i], b_v[i]);
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL add_s_valid[%0d] got %b exp 1", i, s_valid); end
      checks++; if (s_bit !== exp_s[i]) begin errors++; $display("FAIL add_s_bit[%0d] got %b exp %b", i, s_bit, exp_s[i]); end
      if (i < 3) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_early_done[%0d] got %b exp 0", i, done); end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done got %b exp 1", done); end
    checks++; if (sum !== 4'b1000) begin errors++; $display("FAIL add_sum got %b exp 1000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout got %b exp 0", cout); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_after got %b exp 0", busy); end
    checks++; if (sum !== 4'b1000) begin errors++; $display("FAIL add_sum_hold got %b exp 1000", sum); end
    $display("op a=5 b=3 -> sum=%b cout=%b", sum, cout);
  endtask

  task automatic test_carry();
    logic [3:0] ss; int nsv, nd, bd;
    run_op(4'd9, 4'd9, 0, 1'b0, ss, nsv, nd, bd);
    checks++; if (sum !== 4'b0010) begin errors++; $display("FAIL carry_sum got %b exp 0010", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry_cout got %b exp 1", cout); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL carry_done_count got %0d exp 1", nd); end
  endtask

  task automatic test_gaps();
    logic [3:0] ss; int nsv, nd, bd;
    run_op(4'd6, 4'd7, 2, 1'b0, ss, nsv, nd, bd);
    checks++; if (sum !== 4'b1101) begin errors++; $display("FAIL gaps_sum got %b exp 1101", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL gaps_cout got %b exp 0", cout); end
    checks++; if (bd !== 0) begin errors++; $display("FAIL gaps_busy_drops got %0d exp 0", bd); end
    checks++; if (nsv !== 4) begin errors++; $display("FAIL gaps_s_valid_count got %0d exp 4", nsv); end
    checks++; if (ss !== 4'b1101) begin errors++; $display("FAIL gaps_s_stream got %b exp 1101", ss); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL gaps_done_count got %0d exp 1", nd); end
  endtask

  task automatic test_ignored();
    logic [3:0] a_v, b_v; int nd;
    a_v = 4'd5; b_v = 4'd3; nd = 0;
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
    cyc();
    bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL idle_bit_valid_s_valid got %b exp 0", s_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_bit_valid_busy got %b exp 0", busy); end
    checks++; if (sum !== 4'b1101) begin errors++; $display("FAIL idle_sum_hold got %b exp 1101", sum); end
    do_start(1'b0);
    send_pair(a_v[0], b_v[0]);
    send_pair(a_v[1], b_v[1]);
    start = 1'b1;
    cyc();
    start = 1'b0;
    if (done === 1'b1) nd++;
    send_pair(a_v[2], b_v[2]);
    if (done === 1'b1) nd++;
    send_pair(a_v[3], b_v[3]);
    if (done === 1'b1) nd++;
    checks++; if (sum !== 4'b1000) begin errors++; $display("FAIL ignored_sum got %b exp 1000", sum); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    if (done === 1'b1) nd++;
    checks++; if (nd !== 1) begin errors++; $display("FAIL ignored_done_count got %0d exp 1", nd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done_busy got %b exp 0", busy); end
    $display("op a=5 b=3 with stray start/bit_valid -> sum=%b dones=%0d", sum, nd);
  endtask

  task automatic test_reset_mid();
    logic [3:0] ss; int nsv, nd, bd;
    do_start(1'b0);
    send_pair(1'b1, 1'b1);
    send_pair(1'b0, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rmid_s_valid got %b exp 0", s_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done); end
    checks++; if (sum !== 4'b0000) begin errors++; $display("FAIL rmid_sum got %b exp 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rmid_cout got %b exp 0", cout); end
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done === 1'b1) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rmid_stray_done got %0d exp 0", nd); end
    $display("reset mid-operation");
    run_op(4'd1, 4'd1, 0, 1'b0, ss, nsv, nd, bd);
    checks++; if (sum !== 4'b0010) begin errors++; $display("FAIL fresh_sum got %b exp 0010", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL fresh_cout got %b exp 0", cout); end
    start = 1'b1; reset = 1'b1;
    cyc();
    start = 1'b0; reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_reset_busy got %b exp 0", busy); end
    $display("start with reset");
  endtask

  task automatic test_back_to_back();
    logic [3:0] ss; int nsv, nd, bd;
    run_op(4'd2, 4'd3, 0, 1'b0, ss, nsv, nd, bd);
    checks++; if (sum !== 4'b0101) begin errors++; $display("FAIL b2b_first_sum got %b exp 0101", sum); end
    run_op(4'd15, 4'd1, 0, 1'b0, ss, nsv, nd, bd);
    checks++; if (sum !== 4'b0000) begin errors++; $display("FAIL b2b_second_sum got %b exp 0000", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL b2b_second_cout got %b exp 1", cout); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL b2b_done_count got %0d exp 1", nd); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [3:0] ss; int nsv, nd, bd;
    run_op(4'd5, 4'd3, 0, 1'b1, ss, nsv, nd, bd);
    checks++; if (sum !== 4'b0010) begin errors++; $display("FAIL sub53_sum got %b exp 0010", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub53_cout got %b exp 1", cout); end
    run_op(4'd3, 4'd5, 0, 1'b1, ss, nsv, nd, bd);
    checks++; if (sum !== 4'b1110) begin errors++; $display("FAIL sub35_sum got %b exp 1110", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub35_cout got %b exp 0", cout); end
    run_op(4'd5, 4'd3, 0, 1'b0, ss, nsv, nd, bd);
    checks++; if (sum !== 4'b1000) begin errors++; $display("FAIL sub_off_sum got %b exp 1000", sum); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_gaps();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
